sync_ram_wait: RTL and testbench

//  Parametrised, clocked data memory for the RISC-CPU bus with a REQ/ACK handshake and programmable wait states.

---
 rtl/sync_ram_wait.sv | 138 +++++++++++++
 tb/tb_sync_ram_wait.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_ram_wait.sv
// Clocked data memory for the RISC-CPU bus with a REQ/ACK handshake and programmable wait states.
// Requests are latched in IDLE, counted down in WAIT, completed with a one-cycle ACK, then DONE returns to IDLE.
module sync_ram_wait #(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 13,
    parameter int                DEPTH       = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 13'h1000,
    parameter int                WAIT_CYCLES = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ENABLE,
    input  logic              REQ,
    input  logic              WE,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [DATA_W-1:0] WDATA,
    output logic [DATA_W-1:0] RDATA,
    output logic              ACK,
    output logic              ERR,
    output logic              BUSY
);

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [7:0]      WAIT_INIT = 8'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   off;
    logic                hit;
    logic [IDX_W-1:0]    idx;
    logic                mem_we;

    // Decode on the latched address only; the extra top bit keeps off < DEPTH free of wrap.
    always_comb begin
        off = addr_q - BASE_ADDR;
        hit = (addr_q >= BASE_ADDR) && ({1'b0, off} < DEPTH_EXT);
        idx = off[IDX_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        mem_we  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ENABLE && REQ) begin
                    addr_d  = ADDRESS;
                    we_d    = WE;
                    wdata_d = WDATA;
                    cnt_d   = WAIT_INIT;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    ack_d   = 1'b1;
                    state_d = ST_DONE;
                    if (!hit) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (we_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem[idx];
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset drops the FSM to IDLE at once, so an in-flight write never reaches the array.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[idx] <= wdata_q;
        end
    end

    assign RDATA = rdata_q;
    assign ACK   = ack_q;
    assign ERR   = err_q;
    assign BUSY  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sync_ram_wait.sv
// Bench for sync_ram_wait: three instances (2 waits/13-bit, 0 waits/13-bit, 1 wait/14-bit)
// checked against an address-keyed reference memory with directed and random accesses.
module tb_sync_ram_wait;

    logic        clk;
    logic        rst;
    logic        en    [3];
    logic        req   [3];
    logic        we    [3];
    logic [13:0] addr  [3];
    logic [7:0]  wdata [3];
    logic [7:0]  rdata [3];
    logic        ack   [3];
    logic        err   [3];
    logic        busy  [3];

    int total = 0;
    int bad   = 0;

    logic [7:0] mdl [int];
    logic [7:0] last_rd    [3];
    bit         last_known [3];

    sync_ram_wait #(.DATA_W(8), .ADDR_W(13), .DEPTH(4096), .BASE_ADDR(13'h1000), .WAIT_CYCLES(2)) u_dut_w2 (
        .CLK(clk), .RST(rst), .ENABLE(en[0]), .REQ(req[0]), .WE(we[0]), .ADDRESS(addr[0][12:0]),
        .WDATA(wdata[0]), .RDATA(rdata[0]), .ACK(ack[0]), .ERR(err[0]), .BUSY(busy[0]));

    sync_ram_wait #(.DATA_W(8), .ADDR_W(13), .DEPTH(4096), .BASE_ADDR(13'h1000), .WAIT_CYCLES(0)) u_dut_w0 (
        .CLK(clk), .RST(rst), .ENABLE(en[1]), .REQ(req[1]), .WE(we[1]), .ADDRESS(addr[1][12:0]),
        .WDATA(wdata[1]), .RDATA(rdata[1]), .ACK(ack[1]), .ERR(err[1]), .BUSY(busy[1]));

    sync_ram_wait #(.DATA_W(8), .ADDR_W(14), .DEPTH(4096), .BASE_ADDR(14'h1000), .WAIT_CYCLES(1)) u_dut_a14 (
        .CLK(clk), .RST(rst), .ENABLE(en[2]), .REQ(req[2]), .WE(we[2]), .ADDRESS(addr[2]),
        .WDATA(wdata[2]), .RDATA(rdata[2]), .ACK(ack[2]), .ERR(err[2]), .BUSY(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int waits(input int d);
        case (d)
            0:       return 2;
            1:       return 0;
            default: return 1;
        endcase
    endfunction

    function automatic bit is_hit(input int a);
        return (a >= 'h1000) && (a < 'h1000 + 4096);
    endfunction

    function automatic int key(input int d, input int a);
        return d * 65536 + a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input int d);
        check({tag, "_busy"},  32'(busy[d]),  32'd0);
        check({tag, "_ack"},   32'(ack[d]),   32'd0);
        check({tag, "_err"},   32'(err[d]),   32'd0);
        check({tag, "_rdata"}, 32'(rdata[d]), 32'd0);
    endtask

    // One complete transaction with latency, ERR and RDATA checked against the reference memory.
    task automatic access(input int d, input bit w, input logic [13:0] a, input logic [7:0] wd);
        int         lat;
        bit         got;
        bit         h;
        bit         rd_known;
        logic [7:0] exp_rd;
        h = is_hit(int'(a));
        rd_known = 1'b1;
        exp_rd = last_rd[d];
        if (!h) begin
            exp_rd = 8'h00;
        end else if (!w) begin
            if (mdl.exists(key(d, int'(a)))) exp_rd = mdl[key(d, int'(a))];
            else rd_known = 1'b0;
        end else begin
            rd_known = last_known[d];
        end

        @(negedge clk);
        en[d] = 1'b1; req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
        @(posedge clk); #1;
        check("busy_after_accept", 32'(busy[d]), 32'd1);
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (ack[d] === 1'b1) got = 1'b1;
        end
        req[d] = 1'b0;
        en[d]  = 1'b0;
        if (!got) begin
            check("ack_timeout", 32'd0, 32'd1);
        end else begin
            check("ack_latency", 32'(lat), 32'(waits(d) + 1));
            check("err_flag", 32'(err[d]), 32'(!h));
            if (rd_known) check("rdata", 32'(rdata[d]), 32'(exp_rd));
        end

        if (h && w) mdl[key(d, int'(a))] = wd;
        last_rd[d]    = exp_rd;
        last_known[d] = rd_known;

        @(posedge clk); #1;
        check("ack_one_cycle", 32'(ack[d]), 32'd0);
        check("busy_back_idle", 32'(busy[d]), 32'd0);
        if (rd_known) check("rdata_held", 32'(rdata[d]), 32'(exp_rd));
    endtask

    initial begin
        int          acks;
        int          ack_at;
        bit          w;
        int          d;
        logic [13:0] a;
        logic [7:0]  wd;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            en[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
            last_rd[i] = 8'h00; last_known[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check_idle_outputs("reset", i);
        @(negedge clk);
        rst = 1'b0;

        // Two-wait-state write then read at the window base.
        access(0, 1'b1, 14'h1000, 8'hA5);
        access(0, 1'b0, 14'h1000, 8'h00);

        // Window edges, including a miss that must leave both ends untouched.
        access(0, 1'b1, 14'h1FFF, 8'h3C);
        access(0, 1'b0, 14'h1FFF, 8'h00);
        access(0, 1'b1, 14'h0FFF, 8'hEE);
        access(0, 1'b0, 14'h0FFF, 8'h00);
        access(0, 1'b0, 14'h1000, 8'h00);
        access(0, 1'b0, 14'h1FFF, 8'h00);
        access(2, 1'b1, 14'h1FFF, 8'h5C);
        access(2, 1'b0, 14'h1FFF, 8'h00);
        access(2, 1'b1, 14'h2000, 8'h44);
        access(2, 1'b0, 14'h2000, 8'h00);
        access(2, 1'b0, 14'h0FFF, 8'h00);
        access(2, 1'b0, 14'h1FFF, 8'h00);

        // Inputs wiggled while busy must not disturb the latched request.
        access(0, 1'b1, 14'h1008, 8'h99);
        @(negedge clk);
        en[0] = 1'b1; req[0] = 1'b1; we[0] = 1'b1; addr[0] = 14'h1004; wdata[0] = 8'h11;
        @(posedge clk); #1;
        check("busy_proto_accept", 32'(busy[0]), 32'd1);
        acks = 0;
        ack_at = 0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 1) begin addr[0] = 14'h1008; wdata[0] = 8'h22; req[0] = 1'b0; en[0] = 1'b0; end
            if (i == 2) begin req[0] = 1'b1; en[0] = 1'b1; end
            if (i == 3) begin req[0] = 1'b0; en[0] = 1'b0; end
            @(posedge clk); #1;
            if (ack[0] === 1'b1) begin acks++; ack_at = i; end
        end
        check("busy_proto_ack_count", 32'(acks), 32'd1);
        check("busy_proto_ack_edge", 32'(ack_at), 32'd3);
        mdl[key(0, 'h1004)] = 8'h11;
        access(0, 1'b0, 14'h1004, 8'h00);
        access(0, 1'b0, 14'h1008, 8'h00);

        // Asynchronous reset in the middle of a write: outputs clear at once, the write is lost.
        access(0, 1'b1, 14'h1010, 8'h5A);
        access(0, 1'b0, 14'h1010, 8'h00);
        @(negedge clk);
        en[0] = 1'b1; req[0] = 1'b1; we[0] = 1'b1; addr[0] = 14'h1010; wdata[0] = 8'h77;
        @(posedge clk); #1;
        check("abort_busy", 32'(busy[0]), 32'd1);
        req[0] = 1'b0; en[0] = 1'b0;
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("async_reset", 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort_no_ack", 32'(ack[0]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin last_rd[i] = 8'h00; last_known[i] = 1'b1; end
        access(0, 1'b0, 14'h1010, 8'h00);

        // Chip select low: a held REQ is ignored.
        @(negedge clk);
        en[1] = 1'b0; req[1] = 1'b1; addr[1] = 14'h1000; we[1] = 1'b1; wdata[1] = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("disabled_busy", 32'(busy[1]), 32'd0);
            check("disabled_ack", 32'(ack[1]), 32'd0);
        end
        req[1] = 1'b0;
        access(1, 1'b1, 14'h1000, 8'h6B);
        access(1, 1'b0, 14'h1000, 8'h00);

        // Fill a small pool in both 13-bit instances, then run random traffic over it and misses.
        for (int k = 0; k < 16; k++) begin
            access(0, 1'b1, 14'h1000 + 14'(k), 8'($urandom));
            access(1, 1'b1, 14'h1000 + 14'(k), 8'($urandom));
        end
        for (int n = 0; n < 40; n++) begin
            d  = int'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            wd = 8'($urandom);
            if ($urandom_range(0, 9) < 2) a = 14'($urandom_range(0, 'h0FFF));
            else                          a = 14'h1000 + 14'($urandom_range(0, 15));
            access(d, w, a, wd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
